// File: rtl/turbosim_out_reader.sv
// turbosim_out_reader: drains the turbosim output FIFO, keeps a net value table and per-iteration stats
module turbosim_out_reader #(
  parameter int NETS = 300,
  parameter int IDX_W = 14,
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       out_record,
  input  logic              empty,
  output logic              rd,
  input  logic              hold,
  input  logic              go,
  input  logic              done,
  input  logic [IDX_W-1:0]  q_index,
  output logic [1:0]        q_value,
  output logic [15:0]       change_count,
  output logic [15:0]       redundant_count,
  output logic [TIME_W-1:0] last_time,
  output logic              err_time,
  output logic              err_index,
  output logic              iter_done,
  output logic              ready
);
  localparam int AW = $clog2(NETS);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [AW-1:0] init_addr;
  logic [1:0] mem [NETS];
  logic [1:0] val;
  logic [IDX_W-1:0] idx;
  logic [TIME_W-1:0] tm, lt_base;
  logic [15:0] cc_base, rc_base;
  logic idx_ok, run_go, apply, drop, redund, regress, pulse, armed;
  assign val = out_record[31:30];
  assign idx = out_record[16 +: IDX_W];
  assign tm = out_record[TIME_W-1:0];
  assign idx_ok = idx < IDX_W'(NETS);
  assign rd = state == RUN && !empty && !hold;
  assign run_go = state == RUN && go;
  assign apply = rd && idx_ok;
  assign drop = rd && !idx_ok;
  // go clears the iteration first so a same-cycle record starts the new iteration
  assign cc_base = run_go ? '0 : change_count;
  assign rc_base = run_go ? '0 : redundant_count;
  assign lt_base = run_go ? '0 : last_time;
  assign redund = val == mem[AW'(idx)];
  assign regress = tm < lt_base && cc_base != '0;
  assign pulse = state == RUN && armed && done && empty && !go;
  always_comb begin
    state_n = state;
    state_n = (state == INIT && init_addr == AW'(NETS - 1)) ? RUN : state_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      init_addr <= '0;
      ready <= 1'b0;
      q_value <= 2'b10;
      change_count <= '0;
      redundant_count <= '0;
      last_time <= '0;
      err_time <= 1'b0;
      err_index <= 1'b0;
      armed <= 1'b0;
      iter_done <= 1'b0;
    end else begin
      state <= state_n;
      ready <= state_n == RUN;
      init_addr <= init_addr + AW'(state == INIT);
      q_value <= (state == RUN && q_index < IDX_W'(NETS)) ? mem[AW'(q_index)] : 2'b10;
      change_count <= apply ? cc_base + 16'(cc_base != '1) : cc_base;
      redundant_count <= (apply && redund) ? rc_base + 16'(rc_base != '1) : rc_base;
      last_time <= apply ? tm : lt_base;
      err_time <= (err_time && !run_go) || (apply && regress);
      err_index <= (err_index && !run_go) || drop;
      armed <= run_go || (armed && !pulse);
      iter_done <= pulse;
    end
  end
  // table has no reset; INIT sweeps it to x after every reset
  always_ff @(posedge clk) begin
    if (state == INIT || apply) mem[state == INIT ? init_addr : AW'(idx)] <= state == INIT ? 2'b10 : val;
  end
endmodule

// File: doc/turbosim_out_reader.md
Name: turbosim_out_reader

Overview:
Hardware consumer for the turbosim output record stream. It drains the turbosim output FIFO using the rd/empty handshake and decodes each 32-bit record. It keeps a per-net value table, per-iteration change statistics and sticky protocol-error flags. It sits between turbosim and the host/debug logic, and replaces the bench-side display sniffer in synthesizable builds.

Parameters:
NETS, 300, number of net table entries; valid indices 0..NETS-1
IDX_W, 14, net index width (record bits [29:16])
TIME_W, 16, change-time width (record bits [15:0])

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (asserted when 0)
out_record  input  32  turbosim record: [31:30] value code, [29:16] net index, [15:0] change time
empty  input  1  turbosim output FIFO empty; out_record is valid whenever empty=0 (show-ahead)
rd  output  1  pop strobe to turbosim output FIFO
hold  input  1  back-pressure; 1 suppresses rd
go  input  1  iteration start pulse (same signal driven to turbosim)
done  input  1  turbosim done level
q_index  input  IDX_W  net table query index
q_value  output  2  stored value code for q_index; 1-cycle latency
change_count  output  16  records accepted this iteration, saturating
redundant_count  output  16  accepted records whose value equals the stored value, saturating
last_time  output  TIME_W  time field of last accepted record
err_time  output  1  sticky: time regression within iteration
err_index  output  1  sticky: index >= NETS received
iter_done  output  1  one-cycle pulse at end of iteration
ready  output  1  1 once table init completes

Behaviour:
- Value codes: 00=0, 01=1, 10=x, 11=z.
- Reset (rst=0, async): rd=0, q_value=2'b10, all counters/last_time=0, err flags=0, iter_done=0, ready=0, armed=0, state=INIT.
- States:
  - INIT: sweep address 0..NETS-1, writing 2'b10, one entry per cycle; rd=0; go/done ignored. After writing entry NETS-1 -> RUN and ready=1. INIT lasts exactly NETS cycles after rst release.
  - RUN: rd = !empty && !hold (combinational). A record is consumed on any posedge with rd=1.
- Consumed record, index < NETS:
  - table[index] <= value.
  - change_count +1 (saturates at 16'hFFFF).
  - redundant_count +1 if value == old table[index] (saturates).
  - If time < last_time and change_count != 0: err_time <= 1. The record is still applied.
  - last_time <= time.
- Consumed record, index >= NETS: the record is popped but dropped (table and counters unchanged); err_index <= 1.
- go=1 in RUN:
  - Next cycle: change_count, redundant_count, last_time, err_time and err_index are cleared, and armed=1.
  - If a record is consumed in the same cycle, clear happens first, then the record is applied as the first of the new iteration (change_count=1, last_time=record time, no regression check).
  - The table is not cleared.
- iter_done pulses for 1 cycle when armed && done && empty && !go, and clears armed. Records arriving after that are still consumed and counted. There is no second pulse until the next go.
- Query port: q_value <= table[q_index] registered every cycle. If q_index equals the write index in the same cycle, the old value is returned (read-before-write). q_index >= NETS returns 2'b10.
- hold is honoured in the same cycle; no record is lost or duplicated across hold toggles.
- rst asserted mid-iteration: immediate return to reset values. Any FIFO content is left to turbosim's own reset. The table is re-initialised by INIT.

Test Plan:
- Reset release -> ready=0 for exactly 300 cycles, then 1. Query index 0, 150 and 299 -> q_value=2'b10. rd stays 0 during INIT even with empty=0.
- go, then records {01,idx 5,t=100}, {00,idx 5,t=120}, {01,idx 7,t=130}, empty after -> change_count=3, redundant_count=0, last_time=130, query idx5 -> 00, idx7 -> 01. With done=1, exactly one iter_done pulse.
- Record {01,idx 5,t=200}, then {01,idx 5,t=150} -> err_time=1, redundant_count=1, last_time=150. Next go -> err_time=0, counters 0.
- Record {10,idx 300,t=10} -> popped (rd=1 one cycle), err_index=1, change_count unchanged, no table write.
- Stream of 5 records with hold toggled 1/0 every cycle -> exactly 5 rd pulses, change_count=5, order preserved.
- go coincident with a consumed record t=40 -> change_count=1, last_time=40, no err_time. Then rst=0 mid-stream -> all outputs at reset values asynchronously.
